// File: rtl/kinase_valve_sequencer.sv
// kinase_valve_sequencer: stored-program valve/pump sequencer for a kinase_activity chain.
// Define FLUSH_CHECK_EN to compare flush_sense against the drive at the end of each settle.
module kinase_valve_sequencer #(
   parameter int STEP_DEPTH = 16,
   parameter int DWELL_W = 16,
   parameter int CTRL_A_W = 13,
   parameter int CTRL_S_W = 4,
   parameter int PUMP_DIV = 100,
   parameter int SETTLE = 8,
   parameter int AW = $clog2(STEP_DEPTH),
   parameter int SW = DWELL_W + CTRL_A_W + CTRL_S_W + 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         prog_we,
   input  logic [AW-1:0]                prog_addr,
   input  logic [SW-1:0]                prog_data,
   input  logic [AW-1:0]                last_step,
   input  logic                         start,
   input  logic                         abort,
   input  logic [CTRL_A_W+CTRL_S_W-1:0] flush_sense,
   output logic [CTRL_A_W-1:0]          ctrl_a,
   output logic [CTRL_S_W-1:0]          ctrl_s,
   output logic [2:0]                   pump_a,
   output logic [1:0]                   pump_b,
   output logic                         busy,
   output logic                         done,
   output logic                         err,
   output logic [AW-1:0]                step_idx
);
`ifdef FLUSH_CHECK_EN
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DWELL, S_SETL, S_DONE, S_ERR} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DWELL, S_SETL, S_DONE} state_t;
`endif
   localparam int DVW = $clog2(PUMP_DIV + 1);
   state_t state, state_nx;
   logic [SW-1:0] mem [STEP_DEPTH];
   logic [AW-1:0] last_r;
   logic [DWELL_W-1:0] cnt;
   logic [DVW-1:0] div;
   logic [1:0] pa_ph;
   logic pb_ph, pa_on, pb_on, live, cnt_z, at_last, go, pwrap, fail;
   assign busy = state == S_LOAD || state == S_DWELL || state == S_SETL;
   assign done = state == S_DONE;
   assign cnt_z = cnt == '0;
   assign at_last = step_idx == last_r;
   assign go = state == S_IDLE && start;
   assign pwrap = div == DVW'(PUMP_DIV - 1);
   // live stays low after reset/abort/flush failure so every output reads vented
   assign pump_a = !live ? 3'b000 : !pa_on ? 3'b111 :
                   pa_ph == 2'd0 ? 3'b110 : pa_ph == 2'd1 ? 3'b101 : 3'b011;
   assign pump_b = !live ? 2'b00 : !pb_on ? 2'b11 : pb_ph ? 2'b01 : 2'b10;
`ifdef FLUSH_CHECK_EN
   assign fail = state == S_SETL && cnt_z && flush_sense != {ctrl_s, ctrl_a};
   always_ff @(posedge clk)
      if (!rst_n) err <= 1'b0;
      else if (abort) err <= err;
      else if (fail) err <= 1'b1;
      else if (go) err <= 1'b0;
`else
   logic unused_sense;
   assign unused_sense = ^flush_sense;
   assign fail = 1'b0;
   assign err = 1'b0;
`endif
   always_ff @(posedge clk)
      state <= !rst_n ? S_IDLE : state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  state_nx = start ? S_LOAD : S_IDLE;
         S_LOAD:  state_nx = S_DWELL;
         S_DWELL: state_nx = cnt_z ? S_SETL : S_DWELL;
         S_SETL:  state_nx = !cnt_z ? S_SETL : at_last ? S_DONE : S_LOAD;
         default: state_nx = S_IDLE;
      endcase
`ifdef FLUSH_CHECK_EN
      if (fail) state_nx = S_ERR;
`endif
      if (abort) state_nx = S_IDLE;
   end
   always_ff @(posedge clk)
      if (prog_we && !busy) mem[prog_addr] <= prog_data;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         {ctrl_a, ctrl_s, pa_on, pb_on, live} <= '0;
         {cnt, div, pa_ph, pb_ph, step_idx, last_r} <= '0;
      end else if (abort || fail) begin
         {ctrl_a, ctrl_s, pa_on, pb_on, live} <= '0;
      end else begin
         if (go) begin
            {div, pa_ph, pb_ph, step_idx} <= '0;
            last_r <= last_step;
         end
         // pump phase runs across step boundaries; only a new start rewinds it
         if (busy) begin
            div <= pwrap ? '0 : div + 1'b1;
            if (pwrap) begin
               pa_ph <= pa_ph == 2'd2 ? 2'd0 : pa_ph + 1'b1;
               pb_ph <= ~pb_ph;
            end
         end
         if (state == S_LOAD) begin
            {pb_on, pa_on, ctrl_s, ctrl_a, cnt} <= mem[step_idx];
            live <= 1'b1;
         end
         if (state == S_DWELL) cnt <= cnt_z ? DWELL_W'(SETTLE - 1) : cnt - 1'b1;
         if (state == S_SETL) begin
            cnt <= cnt_z ? '0 : cnt - 1'b1;
            if (cnt_z && !at_last) step_idx <= step_idx + 1'b1;
         end
      end
   end
endmodule
